// File: rtl/sreg_frame.sv
// sreg_frame: SPI-style slave shift register, serial pins oversampled on clk.
// Define SREG_SYNC2_EN for two-stage input synchronisers (latency 3); otherwise one stage (latency 2).
module sreg_frame #(
  parameter int DWIDTH    = 21,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              sdi,
  output logic              sdo,
  input  logic [DWIDTH-1:0] par_in,
  output logic [DWIDTH-1:0] par_out,
  output logic              valid,
  output logic              busy
);

`ifdef SREG_SYNC2_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 1;
`endif
  localparam int CW = $clog2(DWIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWIDTH - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] rx_q, rx_d;
  logic [DWIDTH-1:0] tx_q, tx_d;
  logic [DWIDTH-1:0] par_out_q, par_out_d;
  logic              valid_q, valid_d;

  logic              sclk_s, cs_s, sdi_s;
  logic              cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [DWIDTH-1:0] rx_shift, tx_shift;

  // Oldest stage is the synchronised value; the cast drops the bit that falls off the end.
  always_comb begin
    sclk_sync_d = SYNC_STAGES'({sclk_sync_q, sclk});
    cs_sync_d   = SYNC_STAGES'({cs_sync_q, cs_n});
    sdi_sync_d  = SYNC_STAGES'({sdi_sync_q, sdi});
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sdi_s       = sdi_sync_q[SYNC_STAGES-1];
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
  end

  // Clock edges only count inside a frame, so a coincident cs_n rise masks them.
  always_comb begin
    cs_fall   = cs_hist_q & ~cs_s;
    cs_rise   = ~cs_hist_q & cs_s;
    sclk_rise = ~sclk_hist_q & sclk_s & ~cs_s;
    sclk_fall = sclk_hist_q & ~sclk_s & ~cs_s;
  end

  always_comb begin
    if (MSB_FIRST) begin
      rx_shift = {rx_q[DWIDTH-2:0], sdi_s};
      tx_shift = {tx_q[DWIDTH-2:0], 1'b0};
    end else begin
      rx_shift = {sdi_s, rx_q[DWIDTH-1:1]};
      tx_shift = {1'b0, tx_q[DWIDTH-1:1]};
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    par_out_d = par_out_q;
    valid_d   = 1'b0;
    if (cs_rise) begin
      cnt_d = '0;
      rx_d  = '0;
      tx_d  = '0;
    end else if (cs_fall) begin
      cnt_d = '0;
      rx_d  = '0;
      tx_d  = par_in;
    end else if (sclk_rise) begin
      rx_d = rx_shift;
      if (cnt_q == CNT_LAST) begin
        par_out_d = rx_shift;
        valid_d   = 1'b1;
        cnt_d     = '0;
        tx_d      = par_in;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (sclk_fall) begin
      tx_d = tx_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      par_out_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      par_out_q   <= par_out_d;
      valid_q     <= valid_d;
    end
  end

  assign sdo     = MSB_FIRST ? tx_q[DWIDTH-1] : tx_q[0];
  assign par_out = par_out_q;
  assign valid   = valid_q;
  assign busy    = ~cs_s;

endmodule
